// File: rtl/xor6_arbiter.sv
// Round-robin arbiter that shares one 6-bit XOR datapath among four requesters.
// The winner's operands are captured, XORed, and the result is held with its ID until acknowledged.

module xor6 #(
  parameter int W = 6
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y
);
  assign o_y = i_a ^ i_b;
endmodule

module xor6_arbiter #(
  parameter int W = 6,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_flat,
  input  logic [N*W-1:0] b_flat,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   result,
  output logic [1:0]     result_id,
  output logic           result_valid,
  input  logic           res_ack,
  output logic           busy,
  output logic [1:0]     dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [1:0]   r_ptr;
  logic [1:0]   r_id;
  logic [W-1:0] r_op_a;
  logic [W-1:0] r_op_b;
  logic [N-1:0] r_gnt;
  logic [W-1:0] r_result;
  logic [1:0]   r_result_id;
  logic         r_result_valid;

  logic         w_found;
  logic [1:0]   w_winner;
  logic [N-1:0] w_onehot;
  logic         w_grant;
  logic         w_complete;
  logic         w_release;
  logic [W-1:0] w_xor;

  // Search upward from the pointer, wrapping 3 -> 0; first set request wins.
  always_comb begin
    logic [1:0] v_idx;
    w_found  = 1'b0;
    w_winner = r_ptr;
    v_idx    = r_ptr;
    for (int k = 0; k < N; k++) begin
      v_idx = r_ptr + 2'(k);
      if (!w_found && req[v_idx]) begin
        w_found  = 1'b1;
        w_winner = v_idx;
      end
    end
  end

  assign w_onehot = N'(1) << w_winner;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_complete  = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_complete  = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (res_ack) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  xor6 #(.W(W)) u_xor6 (
    .i_a(r_op_a),
    .i_b(r_op_b),
    .o_y(w_xor)
  );

  // Operands are sampled only on the granting edge; later operand changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr          <= '0;
      r_id           <= '0;
      r_op_a         <= '0;
      r_op_b         <= '0;
      r_gnt          <= '0;
      r_result       <= '0;
      r_result_id    <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_gnt <= w_grant ? w_onehot : '0;
      if (w_grant) begin
        r_op_a <= a_flat[int'(w_winner)*W +: W];
        r_op_b <= b_flat[int'(w_winner)*W +: W];
        r_id   <= w_winner;
        r_ptr  <= w_winner + 2'd1;
      end
      if (w_complete) begin
        r_result       <= w_xor;
        r_result_id    <= r_id;
        r_result_valid <= 1'b1;
      end
      if (w_release) begin
        r_result_valid <= 1'b0;
      end
    end
  end

  assign gnt          = r_gnt;
  assign result       = r_result;
  assign result_id    = r_result_id;
  assign result_valid = r_result_valid;
  assign busy         = (r_state != S_IDLE);
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_xor6_arbiter.sv
// Bench for xor6_arbiter: directed operations with a scoreboard for grants and results.
// Handshake: a result is presented when result_valid rises and is retired by res_ack while valid.

module tb_xor6_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [23:0] a_flat;
  logic [23:0] b_flat;
  logic [3:0]  gnt;
  logic [5:0]  result;
  logic [1:0]  result_id;
  logic        result_valid;
  logic        res_ack;
  logic        busy;
  logic [1:0]  dbg_state;

  logic [7:0]  exp_q[$];
  logic [3:0]  exp_gnt_q[$];
  logic [5:0]  a_tab[4];
  logic [5:0]  b_tab[4];
  logic [5:0]  exp_res[4];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_gnt_cyc;
  logic        prev_valid;

  xor6_arbiter dut (
    .clk(clk), .reset_n(reset_n), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .gnt(gnt), .result(result), .result_id(result_id), .result_valid(result_valid),
    .res_ack(res_ack), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_operands();
    for (int i = 0; i < 4; i++) begin
      a_flat[i*6 +: 6] = a_tab[i];
      b_flat[i*6 +: 6] = b_tab[i];
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Grant to requester w, hold the result for hold_cycles with scrambled operands, then ack.
  task automatic do_op(input logic [3:0] r, input int w, input logic [3:0] r_after,
                       input int hold_cycles, input bit check_gap);
    req = r;
    exp_gnt_q.push_back(4'(1) << w);
    exp_q.push_back({2'(w), exp_res[w]});
    tick();
    check("gnt_onehot", gnt, 4'(1) << w);
    check("busy_after_grant", busy, 1);
    check("valid_low_in_exec", result_valid, 0);
    if (check_gap) check("grant_interval", cyc - last_gnt_cyc, 3);
    last_gnt_cyc = cyc;
    req = r_after;
    tick();
    check("gnt_single_cycle", gnt, 0);
    check("valid_after_exec", result_valid, 1);
    check("result_value", result, exp_res[w]);
    check("result_id", result_id, w);
    for (int i = 0; i < hold_cycles; i++) begin
      a_flat = ~a_flat ^ 24'(i * 24'h111111);
      b_flat = b_flat + 24'h0a5a5a;
      tick();
      check("hold_result", result, exp_res[w]);
      check("hold_valid", result_valid, 1);
    end
    load_operands();
    res_ack = 1'b1;
    req = 4'b0000;
    tick();
    res_ack = 1'b0;
    check("valid_after_ack", result_valid, 0);
    check("busy_after_ack", busy, 0);
    check("result_kept_after_ack", result, exp_res[w]);
  endtask

  // Monitor: retires scoreboard entries when a grant or a new result appears.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
    end else begin
      if (gnt != 4'b0000) begin
        if (exp_gnt_q.size() == 0) check("unexpected_gnt", gnt, 0);
        else check("sb_gnt", gnt, exp_gnt_q.pop_front());
      end
      if (result_valid && !prev_valid) begin
        if (exp_q.size() == 0) check("unexpected_result", {result_id, result}, 8'hff);
        else check("sb_result", {result_id, result}, exp_q.pop_front());
      end
      prev_valid = result_valid;
    end
  end

  initial begin
    a_tab[0] = 6'b000111; b_tab[0] = 6'b000001; exp_res[0] = 6'b000110;
    a_tab[1] = 6'b111000; b_tab[1] = 6'b101000; exp_res[1] = 6'b010000;
    a_tab[2] = 6'b101010; b_tab[2] = 6'b110011; exp_res[2] = 6'b011001;
    a_tab[3] = 6'b111111; b_tab[3] = 6'b010101; exp_res[3] = 6'b101010;
    reset_n = 1'b0;
    req = 4'b0000;
    res_ack = 1'b0;
    a_flat = '0;
    b_flat = '0;
    last_gnt_cyc = 0;
    prev_valid = 1'b0;
    load_operands();
    #2;
    check("rst_gnt", gnt, 0);
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    apply_reset();

    // Single request with a long hold and changing operands.
    do_op(4'b0100, 2, 4'b0000, 5, 1'b0);

    // Fairness from reset: all requesters held, ack immediately.
    apply_reset();
    do_op(4'b1111, 0, 4'b1110, 0, 1'b0);
    do_op(4'b1111, 1, 4'b1101, 0, 1'b1);
    do_op(4'b1111, 2, 4'b1011, 0, 1'b1);
    do_op(4'b1111, 3, 4'b0111, 0, 1'b1);
    do_op(4'b1111, 0, 4'b1110, 0, 1'b1);

    // Pointer wrap after a grant to 3.
    do_op(4'b1000, 3, 4'b0000, 0, 1'b0);
    do_op(4'b1001, 0, 4'b1000, 0, 1'b0);

    // Request raised during HOLD must wait for the ack.
    req = 4'b0100;
    exp_gnt_q.push_back(4'b0100);
    exp_q.push_back({2'd2, exp_res[2]});
    tick();
    check("hold_case_gnt", gnt, 4'b0100);
    req = 4'b0000;
    tick();
    check("hold_case_valid", result_valid, 1);
    req = 4'b0010;
    exp_gnt_q.push_back(4'b0010);
    exp_q.push_back({2'd1, exp_res[1]});
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_gnt_in_hold", gnt, 0);
    end
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    check("no_gnt_at_ack_edge", gnt, 0);
    check("valid_dropped_at_ack", result_valid, 0);
    tick();
    check("gnt_after_ack", gnt, 4'b0010);
    req = 4'b0000;
    tick();
    check("hold_case_result", result, exp_res[1]);
    check("hold_case_id", result_id, 1);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;

    // Reset during EXEC discards the operation and clears the pointer.
    req = 4'b1000;
    tick();
    check("pre_reset_gnt", gnt, 4'b1000);
    req = 4'b0000;
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_gnt", gnt, 0);
    check("midrst_result", result, 0);
    check("midrst_id", result_id, 0);
    check("midrst_valid", result_valid, 0);
    check("midrst_busy", busy, 0);
    tick();
    check("inrst_valid", result_valid, 0);
    tick();
    reset_n = 1'b1;
    req = 4'b0011;
    exp_gnt_q.push_back(4'b0001);
    exp_q.push_back({2'd0, exp_res[0]});
    tick();
    check("post_reset_gnt", gnt, 4'b0001);
    req = 4'b0010;
    tick();
    check("post_reset_result", result, exp_res[0]);
    check("post_reset_id", result_id, 0);
    req = 4'b0000;
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    tick();
    tick();
    check("gnt_q_drained", exp_gnt_q.size(), 0);
    check("result_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
